// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register bit indices, oversampling factor and FSM state types
package uart_pkg;
  localparam int OVERSAMPLE = 16;

  localparam int CTRL_RX_EN    = 0;
  localparam int CTRL_TX_EN    = 1;
  localparam int CTRL_RX_IE    = 2;
  localparam int CTRL_TX_IE    = 3;
  localparam int CTRL_ERR_IE   = 4;
  localparam int CTRL_LOOPBACK = 5;

  localparam int STAT_RX_AVAIL    = 0;
  localparam int STAT_TX_EMPTY    = 1;
  localparam int STAT_TX_FULL     = 2;
  localparam int STAT_RX_OVERRUN  = 3;
  localparam int STAT_FRAMING_ERR = 4;
  localparam int STAT_TX_DROP     = 5;
  localparam int STAT_TX_BUSY     = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through synchronous FIFO, power-of-2 depth
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/wb_uart_fifo.sv
// rtl/wb_uart_fifo.sv - FASM-bus UART: 8N1, 16x oversampled RX, baud divisor, TX/RX FIFOs, level irq
module wb_uart_fifo
  import uart_pkg::*;
#(
  parameter logic [7:0]  REG_ADDR_CTRL    = 8'hC0,
  parameter logic [7:0]  REG_ADDR_STAT    = 8'hC1,
  parameter logic [7:0]  REG_ADDR_DATA    = 8'hC2,
  parameter logic [7:0]  REG_ADDR_BAUD_LO = 8'hC3,
  parameter logic [7:0]  REG_ADDR_BAUD_HI = 8'hC4,
  parameter int          TX_FIFO_DEPTH    = 8,
  parameter int          RX_FIFO_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd53
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] adr_wr_i,
  input  logic [7:0] adr_rd_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  input  logic       UART_RXD,
  output logic       UART_TXD,
  output logic       irq
);
  logic [5:0]  ctrl_q, ctrl_d;
  logic [2:0]  err_q, err_d;  // {TX_DROP, FRAMING_ERR, RX_OVERRUN}
  logic [15:0] baud_q, baud_d, div_q, div_d, cnt_q, cnt_d;
  logic        irq_q, irq_d, baud_tick;

  logic wr_ctrl, wr_stat, wr_data, wr_blo, wr_bhi, rd_data;
  assign wr_ctrl = stb_i & we_i & (adr_wr_i == REG_ADDR_CTRL);
  assign wr_stat = stb_i & we_i & (adr_wr_i == REG_ADDR_STAT);
  assign wr_data = stb_i & we_i & (adr_wr_i == REG_ADDR_DATA);
  assign wr_blo  = stb_i & we_i & (adr_wr_i == REG_ADDR_BAUD_LO);
  assign wr_bhi  = stb_i & we_i & (adr_wr_i == REG_ADDR_BAUD_HI);
  assign rd_data = stb_i & ~we_i & (adr_rd_i == REG_ADDR_DATA);
  assign ack_o   = stb_i;

  logic [7:0] tx_dout, rx_dout;
  logic       tx_empty, tx_full, tx_pop, rx_empty, rx_full, rx_push;
  logic [$clog2(TX_FIFO_DEPTH):0] tx_count;
  logic [$clog2(RX_FIFO_DEPTH):0] rx_count;

  tx_state_t  tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_last;

  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [1:0] sync_q;
  logic       rx_prev_q, rx_in, rx_mid, rx_last, set_ovr, set_frm;

  logic tx_drop, tx_busy, tx_empty_stat, rx_avail;
  assign tx_drop       = wr_data & tx_full & ~tx_pop;
  assign tx_busy       = (tx_state_q != TX_IDLE);
  assign tx_empty_stat = (tx_count == '0) & ~tx_busy;
  assign rx_avail      = (rx_count != '0);

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(wr_data), .pop(tx_pop), .din(dat_i),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rd_data & ~rx_empty), .din(rx_shift_q),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  // A new divisor is only adopted at a reload so a running tick period is never truncated.
  assign baud_tick = (cnt_q == div_q);

  always_comb begin
    ctrl_d = wr_ctrl ? dat_i[5:0] : ctrl_q;
    err_d  = (err_q & ~(wr_stat ? dat_i[5:3] : 3'b000)) | {tx_drop, set_frm, set_ovr};
    baud_d = baud_q;
    if (wr_blo) baud_d[7:0]  = dat_i;
    if (wr_bhi) baud_d[15:8] = dat_i;
    div_d  = baud_tick ? baud_q : div_q;
    cnt_d  = (wr_blo | wr_bhi | baud_tick) ? 16'd0 : cnt_q + 16'd1;
    irq_d  = (ctrl_q[CTRL_RX_IE] & rx_avail) | (ctrl_q[CTRL_TX_IE] & tx_empty_stat) |
             (ctrl_q[CTRL_ERR_IE] & (|err_q));
  end

  assign tx_last = baud_tick & (tx_tick_q == 4'(OVERSAMPLE - 1));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    if (tx_busy && baud_tick) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      TX_IDLE: if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
        tx_state_d = TX_START;
        tx_pop     = 1'b1;
        tx_shift_d = tx_dout;
        tx_tick_d  = 4'd0;
        tx_bit_d   = 3'd0;
      end
      TX_START: if (tx_last) tx_state_d = TX_DATA;
      TX_DATA: if (tx_last) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_last) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign UART_TXD = (tx_state_q == TX_START) ? 1'b0 :
                    (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;

  assign rx_in   = sync_q[1];
  assign rx_mid  = baud_tick & (rx_tick_q == 4'(OVERSAMPLE/2 - 1));
  assign rx_last = baud_tick & (rx_tick_q == 4'(OVERSAMPLE - 1));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_frm    = 1'b0;
    if (rx_state_q != RX_IDLE && baud_tick) rx_tick_d = rx_tick_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_in) begin
        rx_state_d = RX_START;
        rx_tick_d  = 4'd0;
        rx_bit_d   = 3'd0;
      end
      RX_START: begin
        if (rx_mid && rx_in)  rx_state_d = RX_IDLE;
        else if (rx_last)     rx_state_d = RX_DATA;
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_d = {rx_in, rx_shift_q[7:1]};
        if (rx_last) begin
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: if (rx_mid) begin
        // Back to IDLE at mid-stop so a back-to-back start edge is not missed.
        rx_state_d = RX_IDLE;
        if (!rx_in)       set_frm = 1'b1;
        else if (rx_full) set_ovr = 1'b1;
        else              rx_push = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!ctrl_q[CTRL_RX_EN]) begin
      rx_state_d = RX_IDLE;
      rx_push    = 1'b0;
      set_ovr    = 1'b0;
      set_frm    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      err_q      <= '0;
      baud_q     <= DEFAULT_BAUD_DIV;
      div_q      <= DEFAULT_BAUD_DIV;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
      baud_q     <= baud_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      sync_q     <= {sync_q[0], ctrl_q[CTRL_LOOPBACK] ? UART_TXD : UART_RXD};
      rx_prev_q  <= rx_in;
    end
  end

  assign irq = irq_q;

  always_comb begin
    dat_o = 8'h00;
    if (adr_rd_i == REG_ADDR_CTRL)         dat_o = {2'b00, ctrl_q};
    else if (adr_rd_i == REG_ADDR_STAT)    dat_o = {1'b0, tx_busy, err_q, tx_full, tx_empty_stat, rx_avail};
    else if (adr_rd_i == REG_ADDR_DATA)    dat_o = rx_empty ? 8'h00 : rx_dout;
    else if (adr_rd_i == REG_ADDR_BAUD_LO) dat_o = baud_q[7:0];
    else if (adr_rd_i == REG_ADDR_BAUD_HI) dat_o = baud_q[15:8];
  end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// tb/tb_wb_uart_fifo.sv - directed self-checking bench for wb_uart_fifo
module tb_wb_uart_fifo;
  localparam logic [7:0] A_CTRL = 8'hC0, A_STAT = 8'hC1, A_DATA = 8'hC2, A_BLO = 8'hC3, A_BHI = 8'hC4;

  logic       clk = 1'b0, reset_n = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [7:0] adr_wr_i = 8'h00, adr_rd_i = 8'h00, dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack_o, UART_RXD = 1'b1, UART_TXD, irq;
  int         n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  wb_uart_fifo dut (
    .clk(clk), .reset_n(reset_n), .stb_i(stb_i), .we_i(we_i), .adr_wr_i(adr_wr_i), .adr_rd_i(adr_rd_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .UART_RXD(UART_RXD), .UART_TXD(UART_TXD), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    stb_i = 1'b1; we_i = 1'b1; adr_wr_i = a; dat_i = d;
    @(negedge clk);
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    stb_i = 1'b1; we_i = 1'b0; adr_rd_i = a;
    #1 d = dat_o;
    @(negedge clk);
    stb_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clks);
    @(negedge clk);
    UART_RXD = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      repeat (bit_clks) @(negedge clk);
    end
    UART_RXD = stop_bit;
    repeat (bit_clks) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (bit_clks) @(negedge clk);
  endtask

  // Samples UART_TXD at the middle of each 16-clock bit (divisor 0).
  task automatic capture_frame(output logic [7:0] b, output logic start_ok, output logic stop_bit,
                               output logic seen);
    seen = 1'b0;
    b = 8'h00; start_ok = 1'b0; stop_bit = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (!UART_TXD) seen = 1'b1;
    end
    if (seen) begin
      repeat (8) @(negedge clk);
      start_ok = ~UART_TXD;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = UART_TXD;
      end
      repeat (16) @(negedge clk);
      stop_bit = UART_TXD;
    end
  endtask

  task automatic wait_stat(input int bitn, input logic val, input int budget, output logic ok);
    logic [7:0] d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(A_STAT, d);
      if (d[bitn] == val) ok = 1'b1;
    end
  endtask

  logic [7:0] tx_vec [9] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h99};
  logic [7:0] rx_vec [9] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'hF0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, b;
    logic ok, st, sp, seen;
    int lows;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_txd", UART_TXD, 1'b1);
    chk("rst_irq", irq, 1'b0);
    bus_read(A_CTRL, d);  chk("rst_ctrl", d, 8'h00);
    bus_read(A_STAT, d);  chk("rst_stat", d, 8'h02);
    bus_read(A_BLO, d);   chk("rst_baud_lo", d, 8'h35);
    bus_read(A_BHI, d);   chk("rst_baud_hi", d, 8'h00);
    bus_read(A_DATA, d);  chk("rst_data_empty", d, 8'h00);
    @(negedge clk); stb_i = 1'b1; #1 chk("ack", ack_o, 1'b1); @(negedge clk); stb_i = 1'b0;

    // Test 1: loopback at divisor 0
    bus_write(A_BLO, 8'h00);
    bus_write(A_BHI, 8'h00);
    repeat (60) @(negedge clk);
    bus_write(A_CTRL, 8'h23);
    bus_write(A_DATA, 8'hA5);
    wait_stat(0, 1'b1, 400, ok);
    chk("t1_rx_avail", ok, 1'b1);
    bus_read(A_DATA, d);  chk("t1_data", d, 8'hA5);
    bus_read(A_STAT, d);  chk("t1_avail_clr", d[0], 1'b0);
    repeat (20) @(negedge clk);
    bus_read(A_STAT, d);  chk("t1_stat_idle", d, 8'h02);

    // Test 2: overfill TX FIFO while disabled, then transmit
    bus_write(A_CTRL, 8'h00);
    for (int i = 0; i < 9; i++) bus_write(A_DATA, tx_vec[i]);
    bus_read(A_STAT, d);  chk("t2_full_drop", d, 8'h24);
    bus_write(A_STAT, 8'h20);
    bus_read(A_STAT, d);  chk("t2_drop_w1c", d, 8'h04);
    bus_write(A_CTRL, 8'h02);
    for (int i = 0; i < 8; i++) begin
      capture_frame(b, st, sp, seen);
      chk($sformatf("t2_seen%0d", i), seen, 1'b1);
      chk($sformatf("t2_start%0d", i), st, 1'b1);
      chk($sformatf("t2_byte%0d", i), b, tx_vec[i]);
      chk($sformatf("t2_stop%0d", i), sp, 1'b1);
    end
    wait_stat(1, 1'b1, 100, ok);
    chk("t2_tx_empty", ok, 1'b1);
    bus_read(A_STAT, d);  chk("t2_stat_end", d, 8'h02);

    // Test 3: nine frames into an 8-deep RX FIFO
    bus_write(A_CTRL, 8'h01);
    for (int i = 0; i < 9; i++) send_frame(rx_vec[i], 1'b1, 16);
    bus_read(A_STAT, d);  chk("t3_stat_ovr", d, 8'h0B);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_DATA, d);
      chk($sformatf("t3_byte%0d", i), d, rx_vec[i]);
    end
    bus_read(A_DATA, d);  chk("t3_empty_read", d, 8'h00);
    bus_read(A_STAT, d);  chk("t3_stat_drained", d, 8'h0A);
    bus_write(A_STAT, 8'h08);
    bus_read(A_STAT, d);  chk("t3_ovr_w1c", d, 8'h02);

    // Test 4: framing error and irq latency
    bus_write(A_CTRL, 8'h11);
    chk("t4_irq_pre", irq, 1'b0);
    fork
      send_frame(8'h5A, 1'b0, 16);
      begin
        adr_rd_i = A_STAT;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (dat_o[4]) seen = 1'b1;
        end
        chk("t4_flag_seen", seen, 1'b1);
        chk("t4_irq_same", irq, 1'b0);
        @(negedge clk);
        chk("t4_irq_next", irq, 1'b1);
      end
    join
    bus_read(A_STAT, d);  chk("t4_stat", d, 8'h12);
    bus_write(A_STAT, 8'h10);
    repeat (2) @(negedge clk);
    chk("t4_irq_clr", irq, 1'b0);
    bus_read(A_STAT, d);  chk("t4_stat_clr", d, 8'h02);

    // Test 5: short glitch at divisor 3, then a real frame at the same rate
    bus_write(A_CTRL, 8'h01);
    bus_write(A_BLO, 8'h03);
    repeat (10) @(negedge clk);
    UART_RXD = 1'b0;
    repeat (4) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(A_STAT, d);  chk("t5_no_flag", d, 8'h02);
    chk("t5_rx_idle", dut.rx_state_q, 0);
    send_frame(8'hC3, 1'b1, 64);
    bus_read(A_DATA, d);  chk("t5_frame", d, 8'hC3);

    // Test 6: reset in the middle of a TX frame
    bus_write(A_CTRL, 8'h02);
    bus_write(A_DATA, 8'h81);
    bus_write(A_DATA, 8'h7E);
    bus_write(A_DATA, 8'h42);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (!UART_TXD) seen = 1'b1;
    end
    chk("t6_tx_started", seen, 1'b1);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_txd", UART_TXD, 1'b1);
    chk("t6_irq", irq, 1'b0);
    bus_read(A_CTRL, d);  chk("t6_ctrl", d, 8'h00);
    bus_read(A_STAT, d);  chk("t6_stat", d, 8'h02);
    bus_read(A_BLO, d);   chk("t6_baud", d, 8'h35);
    @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!UART_TXD) lows++;
    end
    chk("t6_no_residual", lows, 0);
    bus_read(A_STAT, d);  chk("t6_stat_after", d, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
